// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: state encoding and bus geometry shared by the line engine and main_memory.
package mem_bus_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_WB, ST_RD, ST_FIN, ST_ERR} state_t;
    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_WORDS_PER_LINE = 4;
    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction
    function automatic int word_off_w(input int data_w);
        return $clog2(bytes_per_word(data_w));
    endfunction
    function automatic int line_off_w(input int data_w, input int words);
        return word_off_w(data_w) + $clog2(words);
    endfunction
endpackage

// File: rtl/mem_ack_timer.sv
// mem_ack_timer: counts unacknowledged request cycles and flags the last allowed one.
module mem_ack_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) r_cnt <= '0;
        else if (i_en)        r_cnt <= r_cnt + 1'b1;
    end
    // Expire on the TIMEOUT-th waiting cycle so the request is never held longer.
    assign o_expire = i_en && (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_line_engine.sv
// mem_line_engine: writes back a dirty victim line, then fills a new line word by word
// over the main_memory request/acknowledge port.
module mem_line_engine
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int TIMEOUT        = 255
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_start,
    input  logic [ADDR_W-1:0]                 i_fill_addr,
    input  logic                              i_victim_dirty,
    input  logic [ADDR_W-1:0]                 i_victim_addr,
    output logic [$clog2(WORDS_PER_LINE)-1:0] o_wb_idx,
    input  logic [DATA_W-1:0]                 i_wb_data,
    output logic                              o_fill_we,
    output logic [$clog2(WORDS_PER_LINE)-1:0] o_fill_idx,
    output logic [DATA_W-1:0]                 o_fill_data,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_error,
    output logic                              o_mem_req,
    output logic                              o_mem_we,
    output logic [ADDR_W-1:0]                 o_mem_addr,
    output logic [DATA_W-1:0]                 o_mem_wdata,
    input  logic [DATA_W-1:0]                 i_mem_rdata,
    input  logic                              i_mem_ack
);
    localparam int IDX_W  = $clog2(WORDS_PER_LINE);
    localparam int WOFF_W = word_off_w(DATA_W);
    localparam int LOFF_W = line_off_w(DATA_W, WORDS_PER_LINE);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << LOFF_W) - ADDR_W'(1));

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic               r_req;
    logic [IDX_W-1:0]   r_idx;
    logic [ADDR_W-1:0]  r_vbase;
    logic [ADDR_W-1:0]  r_fbase;
    logic               w_ack;
    logic               w_wb;
    logic               w_last;
    logic               w_expire;
    logic [ADDR_W-1:0]  w_addr;

    assign w_ack  = r_req && i_mem_ack;
    assign w_wb   = (r_state == ST_WB);
    assign w_last = (r_idx == IDX_W'(WORDS_PER_LINE - 1));
    assign w_addr = (w_wb ? r_vbase : r_fbase) + (ADDR_W'(r_idx) << WOFF_W);

    // A quiet port keeps the timer cleared, which covers entry into WB and RD.
    mem_ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clr    (!r_req || i_mem_ack),
        .i_en     (r_req && !i_mem_ack),
        .o_expire (w_expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_req   <= 1'b0;
            r_idx   <= '0;
            r_vbase <= '0;
            r_fbase <= '0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: if (i_start) begin
                    r_state <= i_victim_dirty ? ST_WB : ST_RD;
                    r_busy  <= 1'b1;
                    r_idx   <= '0;
                    r_vbase <= i_victim_addr & LINE_MASK;
                    r_fbase <= i_fill_addr & LINE_MASK;
                end
                ST_WB, ST_RD: begin
                    if (!r_req) r_req <= 1'b1;
                    else if (i_mem_ack) begin
                        r_idx <= w_last ? '0 : r_idx + 1'b1;
                        if (w_last) begin
                            r_req   <= 1'b0;
                            r_state <= w_wb ? ST_RD : ST_FIN;
                            r_done  <= !w_wb;
                        end
                    end else if (w_expire) begin
                        r_req   <= 1'b0;
                        r_state <= ST_ERR;
                        r_error <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_error     = r_error;
    assign o_mem_req   = r_req;
    assign o_mem_we    = r_req && w_wb;
    assign o_mem_addr  = r_req ? w_addr : '0;
    assign o_mem_wdata = o_mem_we ? i_wb_data : '0;
    assign o_wb_idx    = r_idx;
    assign o_fill_idx  = r_idx;
    assign o_fill_we   = w_ack && (r_state == ST_RD);
    assign o_fill_data = o_fill_we ? i_mem_rdata : '0;
endmodule

// File: tb/tb_mem_line_engine.sv
// tb_mem_line_engine: random line operations checked against a transaction-queue model
// of the expected memory traffic, fill writes and completion timing.
module tb_mem_line_engine;
    localparam int AW = 32, DW = 32, WPL = 4, TO = 8;

    logic          clk = 1'b0;
    logic          rst, start, vdirty, fill_we, busy, done, error, mem_req, mem_we, mem_ack;
    logic [AW-1:0] fill_addr, victim_addr, mem_addr;
    logic [DW-1:0] wb_data, fill_data, mem_wdata, mem_rdata, wb_pat;
    logic [1:0]    wb_idx, fill_idx;

    always #5 clk = ~clk;
    assign wb_data = wb_pat + DW'(wb_idx);

    mem_line_engine #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(WPL), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_fill_addr(fill_addr),
        .i_victim_dirty(vdirty), .i_victim_addr(victim_addr), .o_wb_idx(wb_idx),
        .i_wb_data(wb_data), .o_fill_we(fill_we), .o_fill_idx(fill_idx),
        .o_fill_data(fill_data), .o_busy(busy), .o_done(done), .o_error(error),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
    );

    typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] data;} txn_t;
    txn_t exp_q[$];
    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_req"}, mem_req, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_fill_we"}, fill_we, 0);
        check({tag, "_fill_idx"}, fill_idx, 0);
        check({tag, "_fill_data"}, fill_data, 0);
        check({tag, "_wb_idx"}, wb_idx, 0);
    endtask

    task automatic run_op(input logic dirty, input logic [AW-1:0] va, input logic [AW-1:0] fa,
                          input int lat_min, input int lat_max, input bit hang,
                          input bit restart, input bit rst_mid, input bit min_lat);
        int  lat, wait_n, rd_n, last_ack;
        bit  fin, exp_fwe;
        exp_q.delete();
        if (dirty)
            for (int i = 0; i < WPL; i++)
                exp_q.push_back('{1'b1, (va & ~32'hF) + 32'(4 * i), wb_pat + DW'(i)});
        for (int i = 0; i < WPL; i++)
            exp_q.push_back('{1'b0, (fa & ~32'hF) + 32'(4 * i), '0});
        start = 1'b1; vdirty = dirty; victim_addr = va; fill_addr = fa;
        @(negedge clk);
        start = 1'b0; vdirty = $urandom; victim_addr = $urandom; fill_addr = $urandom;
        check("accept_busy", busy, 1);
        check("accept_req", mem_req, 0);
        lat = $urandom_range(lat_min, lat_max); wait_n = 0; rd_n = 0; last_ack = -1; fin = 0;
        for (int cyc = 1; cyc < 200 && !fin; cyc++) begin
            if (error) begin
                check("error_expected", hang, 1);
                check("err_wait_cycles", wait_n, TO);
                check("err_req_low", mem_req, 0);
                check("err_no_done", done, 0);
                fin = 1;
            end else if (done) begin
                check("done_expected", hang, 0);
                check("done_after_last_ack", cyc, last_ack + 1);
                check("done_q_empty", exp_q.size(), 0);
                check("done_busy", busy, 1);
                check("done_req_low", mem_req, 0);
                if (min_lat) check("done_latency", cyc, 2 + WPL);
                if (restart) start = 1'b1;
                fin = 1;
            end else begin
                check("busy", busy, 1);
                if (mem_req) begin
                    check("req_expected", exp_q.size() > 0, 1);
                    if (min_lat && last_ack < 0) check("first_req_cycle", cyc, 2);
                    if (exp_q.size() > 0) begin
                        check("mem_we", mem_we, exp_q[0].we);
                        check("mem_addr", mem_addr, exp_q[0].addr);
                        if (exp_q[0].we) check("mem_wdata", mem_wdata, exp_q[0].data);
                        if (rst_mid && !exp_q[0].we && rd_n == 1) begin
                            rst = 1'b1; mem_ack = 1'b0;
                            @(negedge clk);
                            rst = 1'b0;
                            check_zero("mid_reset");
                            return;
                        end
                    end
                    if (!hang && wait_n >= lat) begin
                        mem_ack = 1'b1; mem_rdata = $urandom;
                    end else wait_n++;
                end else mem_ack = ($urandom_range(0, 3) == 0);
                #1;
                exp_fwe = mem_req && mem_ack && exp_q.size() > 0 && !exp_q[0].we;
                check("fill_we", fill_we, exp_fwe);
                if (exp_fwe) begin
                    check("fill_idx", fill_idx, rd_n);
                    check("fill_data", fill_data, mem_rdata);
                end
                if (mem_req && mem_ack && exp_q.size() > 0) begin
                    if (!exp_q[0].we) rd_n++;
                    void'(exp_q.pop_front());
                    wait_n = 0; lat = $urandom_range(lat_min, lat_max); last_ack = cyc;
                end
                if (restart && cyc == 4) begin
                    start = 1'b1; fill_addr = $urandom; vdirty = 1'b1;
                end
                @(negedge clk);
                mem_ack = 1'b0; start = 1'b0;
            end
        end
        check("op_completed", fin, 1);
        @(negedge clk);
        start = 1'b0; mem_ack = 1'b0;
        check("post_busy", busy, 0);
        check("post_done", done, 0);
        check("post_error", error, 0);
        check("post_req", mem_req, 0);
        @(negedge clk);
        check("post2_busy", busy, 0);
        check("post2_req", mem_req, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; vdirty = 1'b0; fill_addr = '0; victim_addr = '0;
        mem_ack = 1'b0; mem_rdata = '0; wb_pat = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        run_op(1'b0, 32'h0, 32'h100, 0, 0, 0, 0, 0, 1);
        wb_pat = 32'hA0;
        run_op(1'b1, 32'h200, 32'h400, 0, 0, 0, 0, 0, 0);
        run_op(1'b1, 32'h600, 32'h800, 3, 3, 0, 0, 0, 0);
        run_op(1'b0, 32'h0, 32'h900, 0, 0, 1, 0, 0, 0);
        run_op(1'b1, 32'hA00, 32'hB00, 0, 0, 1, 0, 0, 0);
        run_op(1'b0, 32'h0, 32'h307, 1, 2, 0, 1, 0, 0);
        run_op(1'b1, 32'hC0D, 32'hE05, 0, 1, 0, 0, 1, 0);
        run_op(1'b0, 32'h0, 32'h1000, 0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 20; n++) begin
            wb_pat = $urandom;
            run_op(1'($urandom), $urandom, $urandom, 0, $urandom_range(0, 3), 0,
                   1'($urandom), 0, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_line_engine.md
Name: mem_line_engine

Overview:
- Cache-side initiator that drives the word-wide request/acknowledge port of main_memory on behalf of one MESI L1 controller.
- On a miss it writes back the dirty victim line (M state) if needed, then fetches the new line word by word into the cache data array.
- Sits between the per-core cache controller and main_memory; it is the only bus master of that memory port.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, word width; byte offset width = log2(DATA_W/8)
- WORDS_PER_LINE, 4, words per cache line; power of two, >= 2
- TIMEOUT, 255, max cycles waiting for mem_ack per word before error

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse: begin line operation; ignored while busy
- fill_addr  in  ADDR_W  line-aligned address of line to fetch (offset bits ignored)
- victim_dirty  in  1  sampled with start; 1 = write back victim first
- victim_addr  in  ADDR_W  line-aligned victim address, sampled with start
- wb_idx  out  log2(WORDS_PER_LINE)  victim word index to cache data array
- wb_data  in  DATA_W  victim word at wb_idx, combinational from cache array
- fill_we  out  1  write strobe to cache data array
- fill_idx  out  log2(WORDS_PER_LINE)  fill word index
- fill_data  out  DATA_W  fill word
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: operation finished successfully
- error  out  1  one-cycle pulse: timeout abort
- mem_req  out  1  request valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  word-aligned byte address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion of current request

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. Reset mid-operation aborts immediately; no done or error pulse.
- Reset values: all outputs 0; state IDLE; word counter 0; timeout counter 0.
- States:
  - IDLE: busy=0. On start, latch addresses and victim_dirty, go to WB if victim_dirty else RD, and set busy=1 the next cycle.
  - WB: mem_req=1, mem_we=1, mem_addr=victim_base+idx*DATA_W/8, mem_wdata=wb_data, wb_idx=idx.
  - RD: mem_req=1, mem_we=0, mem_addr=fill_base+idx*DATA_W/8.
  - FIN: one cycle with done=1, busy=1, then IDLE.
  - ERR: one cycle with error=1, then IDLE.
- Handshake:
  - mem_req rises the cycle after entering WB or RD and holds, with stable address and data, until the cycle mem_ack=1.
  - Each ack consumes exactly one word. idx increments on ack; next word's address and data appear the following cycle with mem_req still high (back-to-back allowed).
  - mem_ack while mem_req=0 is ignored.
- Transitions:
  - WB: ack on the last word (idx=WORDS_PER_LINE-1) resets idx to 0 and enters RD.
  - RD: each ack sets fill_we=1 for exactly that cycle, with fill_idx=idx and fill_data=mem_rdata (combinational passthrough). The last word's ack enters FIN.
  - mem_req is 0 in FIN, ERR and IDLE.
- Timeout: counter clears on each ack and on entering WB/RD, and increments every cycle mem_req=1 without ack. Reaching TIMEOUT goes to ERR; the partial fill is not completed.
- Simultaneous events: start while busy is dropped; start in the FIN cycle is dropped; ack and timeout in the same cycle means ack wins.
- Address arithmetic: offset bits of latched addresses forced to 0; index wrap is impossible (counter width exact, reset explicitly).
- Minimum latency, clean line with ack every cycle: start at T, first mem_req at T+2, done at T+2+WORDS_PER_LINE.

Decomposition:
- Shared package mem_bus_pkg: state enum encoding, DATA_W/ADDR_W defaults, BYTES_PER_WORD and line-offset width constants. main_memory uses the same constants.
- One natural sub-module: mem_ack_timer (timeout counter with clear/enable/expire).
- Address/index datapath stays inline.

Test Plan:
- Clean miss, fill_addr=0x100, ack 1 cycle after each req: 4 reads at 0x100, 0x104, 0x108, 0x10C; 4 fill_we pulses with idx 0..3; done once; busy low after.
- Dirty miss, victim_addr=0x200, wb_data=idx+0xA0: writes to 0x200..0x20C with data 0xA0..0xA3, then reads from fill_addr; no read before the 4th write ack.
- Ack latency of 3 cycles: mem_req, mem_addr and mem_wdata stable across the wait; exactly one fill_we per ack.
- No ack, TIMEOUT=8: error pulses after 8 waiting cycles; mem_req drops; no done; next start accepted.
- start pulsed mid-fill and fill_addr offset bits=0x7: second start ignored; addresses line-aligned.
- reset asserted on the 2nd read word: all outputs 0 the next cycle; a fresh start afterward completes normally.
